// File: rtl/fp_mult_param_pkg.sv
// Shared types and field helpers for the parametrised FP multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MULT,
    NORM,
    ROUND,
    OUT
  } state_t;

  typedef enum logic {
    RNE = 1'b0,
    RTZ = 1'b1
  } rnd_mode_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  // Field extraction works on a zero-extended word so one helper serves any format.
  function automatic logic [63:0] exp_field(input logic [63:0] w, input int exp_w, input int man_w);
    return (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] man_field(input logic [63:0] w, input int man_w);
    return w & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic is_nan(input logic [63:0] w, input int exp_w, input int man_w);
    return (exp_field(w, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) &&
           (man_field(w, man_w) != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] w, input int exp_w, input int man_w);
    return (exp_field(w, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) &&
           (man_field(w, man_w) == 64'd0);
  endfunction

  // Subnormals have a zero exponent field and are deliberately treated as zero.
  function automatic logic is_zero(input logic [63:0] w, input int exp_w, input int man_w);
    return exp_field(w, exp_w, man_w) == 64'd0;
  endfunction

endpackage

// File: rtl/fp_mult_param_if.sv
// Operand/result handshake bundle for the FP multiplier.
interface fp_mult_param_if #(
  parameter int W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          a;
  logic [W-1:0]          b;
  logic                  rnd_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          result;
  fp_mult_pkg::fp_flags_t flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mult_param_round.sv
// Rounding and overflow/underflow resolution for a normalised mantissa.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    s,
  input  logic signed [EXP_W+1:0] e,
  input  logic [MAN_W-1:0]        man,
  input  logic                    g,
  input  logic                    st,
  input  rnd_mode_t               mode,
  output logic [EXP_W+MAN_W:0]    result,
  output fp_flags_t               flags
);

  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] E_ZERO = '0;

  logic                    inc;
  logic                    carry;
  logic [MAN_W-1:0]        man_rnd;
  logic signed [EXP_W+1:0] e_rnd;

  // Apply the rounding increment, absorb a mantissa carry, then clamp the exponent range.
  always_comb begin
    result = '0;
    flags  = '0;
    inc    = (mode == RNE) && g && (st || man[0]);
    {carry, man_rnd} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    e_rnd    = e + {{(EXP_W+1){1'b0}}, carry};
    flags.nx = g | st;
    if (e_rnd >= E_MAX) begin
      flags.of = 1'b1;
      flags.nx = 1'b1;
      if (mode == RNE)
        result = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
        result = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (e_rnd <= E_ZERO) begin
      flags.uf = 1'b1;
      flags.nx = 1'b1;
      result   = {s, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      result = {s, e_rnd[EXP_W-1:0], man_rnd};
    end
  end

endmodule

// File: rtl/fp_mult_param.sv
// Multi-cycle parametrised floating-point multiplier with valid/ready handshakes.
module fp_mult_param
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          reset,
  fp_mult_param_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int EW2  = EXP_W + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t                state, next_state;
  logic [W-1:0]          a_r, b_r, result_r, spec_result, rnd_result;
  rnd_mode_t             mode_r;
  fp_flags_t             flags_r, spec_flags, rnd_flags;
  logic [PW-1:0]         prod_r;
  logic signed [EW2-1:0] exp_r;
  logic                  sign_r, g_r, st_r, spec_hit;
  logic [MAN_W-1:0]      man_r;

  logic s_ab, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

  assign s_ab   = a_r[W-1] ^ b_r[W-1];
  assign nan_a  = is_nan(64'(a_r), EXP_W, MAN_W);
  assign nan_b  = is_nan(64'(b_r), EXP_W, MAN_W);
  assign snan_a = nan_a && !a_r[MAN_W-1];
  assign snan_b = nan_b && !b_r[MAN_W-1];
  assign inf_a  = is_inf(64'(a_r), EXP_W, MAN_W);
  assign inf_b  = is_inf(64'(b_r), EXP_W, MAN_W);
  assign zero_a = is_zero(64'(a_r), EXP_W, MAN_W);
  assign zero_b = is_zero(64'(b_r), EXP_W, MAN_W);

  // Resolve special operands in priority order; anything else needs the full datapath.
  always_comb begin
    spec_hit    = 1'b1;
    spec_result = '0;
    spec_flags  = '0;
    if (nan_a || nan_b) begin
      spec_result   = QNAN;
      spec_flags.nv = snan_a || snan_b;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      spec_result   = QNAN;
      spec_flags.nv = 1'b1;
    end else if (inf_a || inf_b) begin
      spec_result = {s_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      spec_result = {s_ab, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  fp_mult_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .s      (sign_r),
    .e      (exp_r),
    .man    (man_r),
    .g      (g_r),
    .st     (st_r),
    .mode   (mode_r),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Sequence through the pipeline steps, holding in OUT until the consumer takes the result.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = CHECK;
      CHECK:   next_state = spec_hit ? OUT : MULT;
      MULT:    next_state = NORM;
      NORM:    next_state = ROUND;
      ROUND:   next_state = OUT;
      OUT:     if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers advance one step per state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= RNE;
      result_r <= '0;
      flags_r  <= '0;
      prod_r   <= '0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      man_r    <= '0;
      g_r      <= 1'b0;
      st_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r     <= bus.a;
          b_r     <= bus.b;
          mode_r  <= rnd_mode_t'(bus.rnd_mode);
          flags_r <= '0;
        end
        CHECK: if (spec_hit) begin
          result_r <= spec_result;
          flags_r  <= spec_flags;
        end
        MULT: begin
          prod_r <= {1'b1, a_r[MAN_W-1:0]} * {1'b1, b_r[MAN_W-1:0]};
          exp_r  <= EW2'(a_r[W-2 -: EXP_W]) + EW2'(b_r[W-2 -: EXP_W]) - EW2'(BIAS);
          sign_r <= s_ab;
        end
        NORM: begin
          if (prod_r[PW-1]) begin
            man_r <= prod_r[PW-2 -: MAN_W];
            g_r   <= prod_r[MAN_W];
            st_r  <= |prod_r[MAN_W-1:0];
            exp_r <= exp_r + EW2'(1);
          end else begin
            man_r <= prod_r[PW-3 -: MAN_W];
            g_r   <= prod_r[MAN_W-1];
            st_r  <= |prod_r[MAN_W-2:0];
          end
        end
        ROUND: begin
          result_r <= rnd_result;
          flags_r  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;

endmodule

// File: tb/tb_fp_mult_param.sv
// Randomised self-checking bench for fp_mult_param in FP32 and FP16 configurations.
module tb_fp_mult_param;
  import fp_mult_pkg::*;

  bit   clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  fp_mult_param_if #(.W(32)) if32 ();
  fp_mult_param_if #(.W(16)) if16 ();

  fp_mult_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
    end
  endtask

  // Reference multiply from exact integer arithmetic: value = P * 2^(ea+eb-2*bias-2*mw).
  function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b, input bit rtz,
                                   input int ew, input int mw,
                                   output logic [31:0] res, output logic [3:0] fl, output bit special);
    longint unsigned fa, fb, p, q, rem, half, sgn, r, qnan, emax_l;
    int ea, eb, emax, bias, e, k, sh;
    bit nan_a, nan_b;
    emax   = (1 << ew) - 1;
    bias   = (1 << (ew - 1)) - 1;
    emax_l = longint'(emax);
    ea     = int'(a >> mw) & emax;
    eb     = int'(b >> mw) & emax;
    fa     = longint'(a) & ((64'd1 << mw) - 64'd1);
    fb     = longint'(b) & ((64'd1 << mw) - 64'd1);
    sgn    = (a[ew+mw] ^ b[ew+mw]) ? (64'd1 << (ew + mw)) : 64'd0;
    qnan   = (emax_l << mw) | (64'd1 << (mw - 1));
    nan_a  = (ea == emax) && (fa != 0);
    nan_b  = (eb == emax) && (fb != 0);
    fl = 4'b0000;
    r  = 0;
    special = 1'b1;
    if (nan_a || nan_b) begin
      r = qnan;
      fl[3] = (nan_a && fa[mw-1] == 1'b0) || (nan_b && fb[mw-1] == 1'b0);
    end else if ((ea == emax && eb == 0) || (ea == 0 && eb == emax)) begin
      r = qnan;
      fl[3] = 1'b1;
    end else if (ea == emax || eb == emax) begin
      r = sgn | (emax_l << mw);
    end else if (ea == 0 || eb == 0) begin
      r = sgn;
    end else begin
      special = 1'b0;
      p    = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
      k    = ((p >> (2 * mw + 1)) != 0) ? 2 * mw + 1 : 2 * mw;
      e    = ea + eb - bias + (k - 2 * mw);
      sh   = k - mw;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 1;
      if ((q >> (mw + 1)) != 0) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        fl = 4'b0101;
        r  = rtz ? (sgn | ((emax_l - 1) << mw) | ((64'd1 << mw) - 1)) : (sgn | (emax_l << mw));
      end else if (e <= 0) begin
        fl = 4'b0011;
        r  = sgn;
      end else begin
        fl[0] = (rem != 0);
        r = sgn | (longint'(e) << mw) | (q & ((64'd1 << mw) - 1));
      end
    end
    res = r[31:0];
  endfunction

  // Random operand mixing zeros, infinities, NaNs, wide-range and near-unity exponents.
  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int unsigned sel, e, bias, emax;
    logic [31:0] m, s;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    sel  = $urandom_range(0, 9);
    m    = $urandom & ((32'd1 << mw) - 1);
    s    = 32'($urandom_range(0, 1));
    case (sel)
      0:       e = 0;
      1:       begin e = emax; m = '0; end
      2:       e = emax;
      3, 4, 5: e = $urandom_range(1, emax - 1);
      default: e = $urandom_range(bias - 3, bias + 3);
    endcase
    return (s << (ew + mw)) | (32'(e) << mw) | m;
  endfunction

  // Issue one operation on the chosen DUT and collect its result and latency.
  task automatic apply_stimulus(input bit half, input logic [31:0] a, input logic [31:0] b, input bit rtz,
                                output logic [31:0] res, output logic [3:0] fl, output int lat);
    int wait_cnt = 0;
    while (!(half ? if16.in_ready : if32.in_ready) && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (wait_cnt >= 50) check_output("in_ready_wait", half ? if16.in_ready : if32.in_ready, 1);
    if (half) begin
      if16.a = a[15:0]; if16.b = b[15:0]; if16.rnd_mode = rtz; if16.in_valid = 1'b1;
    end else begin
      if32.a = a; if32.b = b; if32.rnd_mode = rtz; if32.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if32.in_valid = 1'b0;
    lat = 0;
    while (!(half ? if16.out_valid : if32.out_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = half ? {16'h0, if16.result} : if32.result;
    fl  = half ? if16.flags : if32.flags;
  endtask

  typedef struct {
    bit          half;
    logic [31:0] a;
    logic [31:0] b;
    bit          rtz;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] res, exp_res, opa, opb;
    logic [3:0]  fl, exp_fl;
    int          lat;
    bit          special, rtz, stable, seen;

    vecs[0] = '{0, 32'h3FC00000, 32'h40000000, 0, 32'h40400000, 4'b0000, 4};
    vecs[1] = '{0, 32'h3F800001, 32'h3FC00000, 0, 32'h3FC00002, 4'b0001, 4};
    vecs[2] = '{0, 32'h3F800001, 32'h3FC00000, 1, 32'h3FC00001, 4'b0001, 4};
    vecs[3] = '{0, 32'h7F000000, 32'h7F000000, 0, 32'h7F800000, 4'b0101, 4};
    vecs[4] = '{0, 32'h7F000000, 32'h7F000000, 1, 32'h7F7FFFFF, 4'b0101, 4};
    vecs[5] = '{0, 32'h80800000, 32'h3F000000, 0, 32'h80000000, 4'b0011, 4};
    vecs[6] = '{0, 32'h00000000, 32'h7F800000, 0, 32'h7FC00000, 4'b1000, 1};
    vecs[7] = '{0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000, 1};
    vecs[8] = '{1, 32'h00003C00, 32'h00004000, 0, 32'h00004000, 4'b0000, 4};
    vecs[9] = '{1, 32'h00007800, 32'h00007800, 0, 32'h00007C00, 4'b0101, 4};

    reset = 1'b0;
    if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.rnd_mode = 0; if32.out_ready = 1;
    if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.rnd_mode = 0; if16.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", if32.in_ready, 1);
    check_output("rst_out_valid", if32.out_valid, 0);
    check_output("rst_result", if32.result, 0);
    check_output("rst_flags", if32.flags, 0);
    check_output("rst_in_ready16", if16.in_ready, 1);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].half, vecs[i].a, vecs[i].b, vecs[i].rtz, res, fl, lat);
      check_output($sformatf("dir%0d_result", i), res, vecs[i].res);
      check_output($sformatf("dir%0d_flags", i), fl, vecs[i].fl);
      check_output($sformatf("dir%0d_latency", i), lat, vecs[i].lat);
    end

    for (int n = 0; n < 300; n++) begin
      bit half;
      half = (n >= 200);
      opa  = half ? rand_op(5, 10) : rand_op(8, 23);
      opb  = half ? rand_op(5, 10) : rand_op(8, 23);
      rtz  = 1'($urandom_range(0, 1));
      ref_mult(opa, opb, rtz, half ? 5 : 8, half ? 10 : 23, exp_res, exp_fl, special);
      apply_stimulus(half, opa, opb, rtz, res, fl, lat);
      check_output($sformatf("rnd%0d_result a=%0h b=%0h", n, opa, opb), res, exp_res);
      check_output($sformatf("rnd%0d_flags a=%0h b=%0h", n, opa, opb), fl, exp_fl);
      check_output($sformatf("rnd%0d_latency", n), lat, special ? 1 : 4);
    end

    // Backpressure: result must stay put while the consumer stalls.
    if32.out_ready = 1'b0;
    apply_stimulus(0, 32'h3FC00000, 32'h40000000, 0, res, fl, lat);
    check_output("bp_first", res, 32'h40400000);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (if32.result !== 32'h40400000 || !if32.out_valid || if32.in_ready) stable = 1'b0;
    end
    check_output("bp_stable", stable, 1);
    check_output("bp_in_ready", if32.in_ready, 0);
    if32.out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_release_in_ready", if32.in_ready, 1);
    check_output("bp_release_out_valid", if32.out_valid, 0);

    // Reset while the operation sits in normalisation.
    if32.a = 32'h3FC00000; if32.b = 32'h40000000; if32.rnd_mode = 0; if32.in_valid = 1'b1;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("midrst_out_valid", if32.out_valid, 0);
    check_output("midrst_in_ready", if32.in_ready, 1);
    check_output("midrst_result", if32.result, 0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if32.out_valid) seen = 1'b1;
    end
    check_output("midrst_no_output", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
